// File: rtl/dq_burst_sequencer.sv
// ---------------------------------------------------------------------------
// dq_burst_sequencer
//
// Turns WR/RD column-command issue pulses into the DQ data-phase strobes.
// Each accepted command waits its programmed latency in an in-order queue,
// then drives an 8-beat burst (wr_en or rd_en with the beat index on
// COL_choice).  A one-cycle clear follows each run of back-to-back bursts.
// A bus-free tracker rejects any command whose data phase would overlap the
// data phase already booked on the shared DQ bus.
//
// Cycle numbering: an issue pulse sampled at rising edge t books beat k
// (k = 0..7) to be visible right after rising edge t+LAT+k.
//
// Ports:
//   CLK         in   system clock, rising edge
//   RST         in   synchronous active-high reset
//   wr_issue    in   WR column command issued (single-cycle pulse)
//   rd_issue    in   RD column command issued (single-cycle pulse)
//   wr_en       out  drive write beat COL_choice onto DQ
//   rd_en       out  capture read beat COL_choice from DQ
//   clear       out  one-cycle datapath clear after a burst run
//   COL_choice  out  beat index 0..7 within the active burst
//   burst_last  out  high on beat 7
//   busy        out  queue not empty or data FSM not idle
//   queue_full  out  outstanding (not yet started) entries == PEND_DEPTH
//   cmd_err     out  sticky rejected-command flag, cleared only by RST
// ---------------------------------------------------------------------------
module dq_burst_sequencer #(
    parameter int WR_LAT     = 10,
    parameter int RD_LAT     = 12,
    parameter int PEND_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       wr_issue,
    input  logic       rd_issue,
    output logic       wr_en,
    output logic       rd_en,
    output logic       clear,
    output logic [2:0] COL_choice,
    output logic       burst_last,
    output logic       busy,
    output logic       queue_full,
    output logic       cmd_err
);

    localparam int OW = $clog2(PEND_DEPTH + 1);
    localparam int IW = $clog2(PEND_DEPTH);

    localparam logic [5:0]    WR_LAT_C = 6'(WR_LAT);
    localparam logic [5:0]    RD_LAT_C = 6'(RD_LAT);
    localparam logic [OW-1:0] DEPTH_C  = OW'(PEND_DEPTH);

    localparam logic DIR_WR = 1'b0;
    localparam logic DIR_RD = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_CLR   = 2'd2
    } state_e;

    // Countdown ageing: saturates at zero once the entry is due.
    function automatic logic [4:0] age_cnt(input logic [4:0] c);
        logic [4:0] r;
        if (c != 5'd0) begin
            r = c - 5'd1;
        end else begin
            r = c;
        end
        return r;
    endfunction

    state_e        state_q, state_d;
    logic [2:0]    col_q, col_d;
    logic          adir_q, adir_d;
    logic [5:0]    free_q, free_d;
    logic [OW-1:0] occ_q, occ_d;
    logic          qdir_q [PEND_DEPTH];
    logic          qdir_d [PEND_DEPTH];
    logic [4:0]    qcnt_q [PEND_DEPTH];
    logic [4:0]    qcnt_d [PEND_DEPTH];
    logic          cmd_err_q, cmd_err_d;
    logic          wr_en_q, wr_en_d;
    logic          rd_en_q, rd_en_d;
    logic          clear_q, clear_d;
    logic          last_q, last_d;
    logic          busy_q, busy_d;
    logic          full_q, full_d;

    logic [5:0]    lat_s;
    logic          accept_s;
    logic          reject_s;
    logic          start_s;
    logic [OW-1:0] slot_s;
    logic [IW-1:0] wr_idx_s;

    // Command admission, bus-free tracker and sticky error.
    always_comb begin
        lat_s    = rd_issue ? RD_LAT_C : WR_LAT_C;
        // A command fits only if its first beat lands at or after the first free bus cycle.
        accept_s = (wr_issue ^ rd_issue) && (lat_s >= free_q) && (occ_q != DEPTH_C);
        reject_s = (wr_issue || rd_issue) && !accept_s;
        start_s  = (occ_q != {OW{1'b0}}) && (qcnt_q[0] == 5'd0);
        if (accept_s) begin
            free_d = lat_s + 6'd7;
        end else if (free_q != 6'd0) begin
            free_d = free_q - 6'd1;
        end else begin
            free_d = free_q;
        end
        cmd_err_d = cmd_err_q || reject_s;
    end

    // Queue next-state: age every entry, shift on pop, append on push.
    always_comb begin
        for (int i = 0; i < PEND_DEPTH - 1; i++) begin
            if (start_s) begin
                qcnt_d[i] = age_cnt(qcnt_q[i+1]);
                qdir_d[i] = qdir_q[i+1];
            end else begin
                qcnt_d[i] = age_cnt(qcnt_q[i]);
                qdir_d[i] = qdir_q[i];
            end
        end
        // The top slot becomes a stale copy after a pop; occupancy masks it.
        qcnt_d[PEND_DEPTH-1] = age_cnt(qcnt_q[PEND_DEPTH-1]);
        qdir_d[PEND_DEPTH-1] = qdir_q[PEND_DEPTH-1];
        // Push lands behind the surviving entries, accounting for a same-cycle pop.
        slot_s   = occ_q - {{(OW-1){1'b0}}, start_s};
        wr_idx_s = slot_s[IW-1:0];
        if (accept_s) begin
            qcnt_d[wr_idx_s] = 5'(lat_s - 6'd1);
            qdir_d[wr_idx_s] = rd_issue ? DIR_RD : DIR_WR;
        end else begin
            qcnt_d[0] = qcnt_d[0];
        end
        occ_d = occ_q + {{(OW-1){1'b0}}, accept_s} - {{(OW-1){1'b0}}, start_s};
    end

    // Data FSM next-state and decoded next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        adir_d  = adir_q;
        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d = ST_BURST;
                    col_d   = 3'd0;
                    adir_d  = qdir_q[0];
                end else begin
                    col_d   = 3'd0;
                end
            end
            ST_BURST: begin
                if (col_q == 3'd7) begin
                    col_d = 3'd0;
                    if (start_s) begin
                        // Seamless hand-over: next burst follows with no clear.
                        state_d = ST_BURST;
                        adir_d  = qdir_q[0];
                    end else begin
                        state_d = ST_CLR;
                    end
                end else begin
                    col_d = col_q + 3'd1;
                end
            end
            ST_CLR: begin
                col_d = 3'd0;
                if (start_s) begin
                    state_d = ST_BURST;
                    adir_d  = qdir_q[0];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                col_d   = 3'd0;
                adir_d  = DIR_WR;
            end
        endcase
        wr_en_d = (state_d == ST_BURST) && (adir_d == DIR_WR);
        rd_en_d = (state_d == ST_BURST) && (adir_d == DIR_RD);
        clear_d = (state_d == ST_CLR);
        last_d  = (state_d == ST_BURST) && (col_d == 3'd7);
        busy_d  = (occ_d != {OW{1'b0}}) || (state_d != ST_IDLE);
        full_d  = (occ_d == DEPTH_C);
    end

    // State, queue and output registers; reset aborts everything silently.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            col_q     <= 3'd0;
            adir_q    <= DIR_WR;
            free_q    <= 6'd0;
            occ_q     <= {OW{1'b0}};
            cmd_err_q <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            clear_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            full_q    <= 1'b0;
            for (int i = 0; i < PEND_DEPTH; i++) begin
                qcnt_q[i] <= 5'd0;
                qdir_q[i] <= DIR_WR;
            end
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            adir_q    <= adir_d;
            free_q    <= free_d;
            occ_q     <= occ_d;
            cmd_err_q <= cmd_err_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            clear_q   <= clear_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            full_q    <= full_d;
            for (int i = 0; i < PEND_DEPTH; i++) begin
                qcnt_q[i] <= qcnt_d[i];
                qdir_q[i] <= qdir_d[i];
            end
        end
    end

    assign wr_en      = wr_en_q;
    assign rd_en      = rd_en_q;
    assign clear      = clear_q;
    assign COL_choice = col_q;
    assign burst_last = last_q;
    assign busy       = busy_q;
    assign queue_full = full_q;
    assign cmd_err    = cmd_err_q;

endmodule
